// File: rtl/ram_wait_ctrl_if.sv
// CPU-to-memory request bus: the CPU drives req/wr/addr/wdata, the RAM answers with rdata/ack/err/busy.
interface ram_wait_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              busy;

   modport master (output req, wr, addr, wdata, input rdata, ack, err, busy);
   modport slave  (input req, wr, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/ram_wait_ctrl.sv
// Single-port synchronous RAM with req/ack handshake, programmable wait states
// and out-of-range detection.
module ram_wait_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int WAIT   = 1
) (
   input  logic             clk,
   input  logic             reset,
   ram_wait_ctrl_if.slave   bus
);
   localparam int CNT_W = 4;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

   if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
      $error("ram_wait_ctrl: WAIT must be in 0..15");
   end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("ram_wait_ctrl: DEPTH must be in 1..2**ADDR_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              wr_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [DATA_W-1:0] rdata_q;
   logic              ack_q;
   logic              err_q;
   logic              busy_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              commit;
   logic              c_wr;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_valid;
   logic [IDX_W-1:0]  c_idx;

   // With no wait states the access commits on the accepting edge, so it must use the live bus values.
   always_comb begin
      commit  = 1'b0;
      c_wr    = wr_l;
      c_addr  = addr_l;
      c_wdata = wdata_l;
      case (state)
         S_IDLE: begin
            if (bus.req && WAIT == 0) begin
               commit  = 1'b1;
               c_wr    = bus.wr;
               c_addr  = bus.addr;
               c_wdata = bus.wdata;
            end
         end
         S_WAIT:  commit = (cnt == CNT_W'(1));
         default: commit = 1'b0;
      endcase
   end

   assign c_valid = {1'b0, c_addr} < DEPTH_L;
   assign c_idx   = c_addr[IDX_W-1:0];

   // Array is never reset; a commit coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (reset && commit && c_wr && c_valid) begin
         mem[c_idx] <= c_wdata;
      end
   end

   // Handshake FSM; every output is a flop so nothing is combinational from req.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         wr_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (commit) begin
            ack_q <= 1'b1;
            err_q <= !c_valid;
            if (c_valid && !c_wr) begin
               rdata_q <= mem[c_idx];
            end
         end
         case (state)
            S_IDLE: begin
               if (bus.req) begin
                  wr_l    <= bus.wr;
                  addr_l  <= bus.addr;
                  wdata_l <= bus.wdata;
                  cnt     <= WAIT_C;
                  busy_q  <= 1'b1;
                  state   <= (WAIT == 0) ? S_ACK : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_ACK;
               end
            end
            S_ACK: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Directed bench for ram_wait_ctrl: three builds (WAIT=1, WAIT=0/DEPTH=768, WAIT=3) share one stimulus bus.
module tb_ram_wait_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       wr = 1'b0;
   logic [9:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [1:0] sel = 2'd0;
   int         checks = 0;
   int         errors = 0;

   ram_wait_ctrl_if #(.DATA_W(8), .ADDR_W(10)) ifa ();
   ram_wait_ctrl_if #(.DATA_W(8), .ADDR_W(10)) ifb ();
   ram_wait_ctrl_if #(.DATA_W(8), .ADDR_W(10)) ifc ();

   ram_wait_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .WAIT(1)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
   ram_wait_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(768),  .WAIT(0)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));
   ram_wait_ctrl #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .WAIT(3)) dut_c (.clk(clk), .reset(rst_n), .bus(ifc));

   assign ifa.req = req && (sel == 2'd0);
   assign ifb.req = req && (sel == 2'd1);
   assign ifc.req = req && (sel == 2'd2);
   assign ifa.wr = wr;     assign ifb.wr = wr;     assign ifc.wr = wr;
   assign ifa.addr = addr; assign ifb.addr = addr; assign ifc.addr = addr;
   assign ifa.wdata = wdata; assign ifb.wdata = wdata; assign ifc.wdata = wdata;

   logic       o_ack, o_err, o_busy;
   logic [7:0] o_rdata;
   assign o_ack   = (sel == 2'd0) ? ifa.ack   : (sel == 2'd1) ? ifb.ack   : ifc.ack;
   assign o_err   = (sel == 2'd0) ? ifa.err   : (sel == 2'd1) ? ifb.err   : ifc.err;
   assign o_busy  = (sel == 2'd0) ? ifa.busy  : (sel == 2'd1) ? ifb.busy  : ifc.busy;
   assign o_rdata = (sel == 2'd0) ? ifa.rdata : (sel == 2'd1) ? ifb.rdata : ifc.rdata;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one access from just after a negedge; returns ack latency, values seen in the
   // ack cycle and number of busy cycles; ends at the first negedge back in IDLE.
   task automatic applyStimulus(input logic w, input logic [9:0] a, input logic [7:0] d,
                                output int lat, output logic e, output logic [7:0] rd,
                                output int bcnt);
      req = 1'b1; wr = w; addr = a; wdata = d;
      lat = 0; bcnt = 0;
      @(negedge clk);
      req = 1'b0; addr = ~a; wdata = ~d;
      lat = 1;
      if (o_busy) bcnt++;
      while (!o_ack && lat < 20) begin
         @(negedge clk);
         lat++;
         if (o_busy) bcnt++;
      end
      e = o_err; rd = o_rdata;
      @(negedge clk);
   endtask

   initial begin
      int lat, bc, acks;
      logic e;
      logic [7:0] rd;

      // reset state
      @(negedge clk);
      checkOutput("reset_ack", {31'd0, ifa.ack}, 32'd0);
      checkOutput("reset_busy", {31'd0, ifa.busy}, 32'd0);
      checkOutput("reset_rdata", {24'd0, ifa.rdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // test 1: WAIT=1 write
      sel = 2'd0;
      applyStimulus(1'b1, 10'h003, 8'hA5, lat, e, rd, bc);
      checkOutput("t1_lat", lat, 32'd2);
      checkOutput("t1_err", {31'd0, e}, 32'd0);
      checkOutput("t1_busy_cycles", bc, 32'd2);
      checkOutput("t1_busy_idle", {31'd0, o_busy}, 32'd0);

      // test 2: read back, then idle hold
      applyStimulus(1'b0, 10'h003, 8'h00, lat, e, rd, bc);
      checkOutput("t2_lat", lat, 32'd2);
      checkOutput("t2_rdata", {24'd0, rd}, 32'hA5);
      repeat (5) @(negedge clk);
      checkOutput("t2_hold_rdata", {24'd0, o_rdata}, 32'hA5);
      checkOutput("t2_hold_ack", {31'd0, o_ack}, 32'd0);

      // test 6: requests while busy are ignored
      applyStimulus(1'b1, 10'h021, 8'h12, lat, e, rd, bc);
      req = 1'b1; wr = 1'b1; addr = 10'h020; wdata = 8'h44;
      @(negedge clk);
      addr = 10'h021; wdata = 8'hEE;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req = 1'b0;
         if (o_ack) acks++;
      end
      checkOutput("t6_ack_count", acks, 32'd1);
      applyStimulus(1'b0, 10'h020, 8'h00, lat, e, rd, bc);
      checkOutput("t6_rdata_020", {24'd0, rd}, 32'h44);
      applyStimulus(1'b0, 10'h021, 8'h00, lat, e, rd, bc);
      checkOutput("t6_rdata_021", {24'd0, rd}, 32'h12);

      // test 3: WAIT=0, req held high across two reads
      sel = 2'd1;
      applyStimulus(1'b1, 10'h000, 8'h11, lat, e, rd, bc);
      checkOutput("t3_wr_lat", lat, 32'd1);
      applyStimulus(1'b1, 10'h001, 8'h22, lat, e, rd, bc);
      req = 1'b1; wr = 1'b0; addr = 10'h000;
      @(negedge clk);
      checkOutput("t3_ack0", {31'd0, o_ack}, 32'd1);
      checkOutput("t3_rdata0", {24'd0, o_rdata}, 32'h11);
      addr = 10'h001;
      @(negedge clk);
      checkOutput("t3_gap_ack", {31'd0, o_ack}, 32'd0);
      @(negedge clk);
      req = 1'b0;
      checkOutput("t3_ack1", {31'd0, o_ack}, 32'd1);
      checkOutput("t3_rdata1", {24'd0, o_rdata}, 32'h22);
      @(negedge clk);

      // test 4: DEPTH=768 boundaries
      applyStimulus(1'b1, 10'h300, 8'h5A, lat, e, rd, bc);
      checkOutput("t4_wr_err", {31'd0, e}, 32'd1);
      applyStimulus(1'b0, 10'h300, 8'h00, lat, e, rd, bc);
      checkOutput("t4_rd_err", {31'd0, e}, 32'd1);
      checkOutput("t4_rd_keep", {24'd0, rd}, 32'h22);
      applyStimulus(1'b1, 10'h2FF, 8'h99, lat, e, rd, bc);
      checkOutput("t4_last_wr_err", {31'd0, e}, 32'd0);
      applyStimulus(1'b0, 10'h2FF, 8'h00, lat, e, rd, bc);
      checkOutput("t4_last_rdata", {24'd0, rd}, 32'h99);
      checkOutput("t4_last_err", {31'd0, e}, 32'd0);

      // test 5: WAIT=3, reset during the second wait cycle
      sel = 2'd2;
      applyStimulus(1'b1, 10'h010, 8'h3C, lat, e, rd, bc);
      checkOutput("t5_lat", lat, 32'd4);
      applyStimulus(1'b0, 10'h010, 8'h00, lat, e, rd, bc);
      checkOutput("t5_pre_rdata", {24'd0, rd}, 32'h3C);
      req = 1'b1; wr = 1'b1; addr = 10'h010; wdata = 8'hFF;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      checkOutput("t5_busy_before", {31'd0, o_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("t5_rst_rdata", {24'd0, o_rdata}, 32'd0);
      checkOutput("t5_rst_ack", {31'd0, o_ack}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_ack) acks++;
      end
      checkOutput("t5_no_ack", acks, 32'd0);
      applyStimulus(1'b0, 10'h010, 8'h00, lat, e, rd, bc);
      checkOutput("t5_old_rdata", {24'd0, rd}, 32'h3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
